// File: rtl/ode_step_sequencer_pkg.sv
// ode_pkg: shared types and constants for the ODE step sequencer.
//   seq_state_t        - sequencer FSM state encoding
//   BUF_A_BASE_DEF     - default base address of state buffer A
//   BUF_B_BASE_DEF     - default base address of state buffer B
//   RETRY_W            - width of the consecutive-rejection counter
package ode_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_INIT       = 4'd1,
    ST_INIT_WAIT  = 4'd2,
    ST_SOLVE      = 4'd3,
    ST_SOLVE_WAIT = 4'd4,
    ST_CHECK      = 4'd5,
    ST_CHECK_WAIT = 4'd6,
    ST_ACCEPT     = 4'd7,
    ST_DONE       = 4'd8,
    ST_FAIL       = 4'd9
  } seq_state_t;

  localparam logic [15:0] BUF_A_BASE_DEF = 16'd16;
  localparam logic [15:0] BUF_B_BASE_DEF = 16'd512;

  // Enough for MAX_RETRIES up to 255.
  localparam int RETRY_W = 8;

endpackage

// File: rtl/ode_step_sequencer_if.sv
// ode_seq_if: bundles the host control/status, step-module and solver
// signals of the ODE step sequencer.
//   host   : go, abort, t_end -> ; busy, finished, failed, time_out,
//            accepted_count <-
//   step   : step_init, step_start -> ; step_done, step_proceed,
//            step_error_failure, step_value <-
//   solver : solver_start, solver_step, x0_address, x1_address -> ;
//            solver_done <-
//   debug  : state_dbg, the sequencer's current FSM state
//
// Handshake semantics: every *_init / *_start output is a single-cycle
// request strobe; the partner answers with a single-cycle *_done pulse,
// and any qualifier (step_proceed, step_error_failure) is valid only in
// the cycle step_done is high. A done pulse counts only while the
// sequencer is waiting for it; at any other time it is dropped.
//
// Modports: master = the sequencer, slave = the host/step/solver side.
interface ode_seq_if
  import ode_pkg::*;
#(
  parameter int WORD_SIZE     = 16,
  parameter int ADDRESS_WIDTH = 16
);
  logic                     go;
  logic                     abort;
  logic [WORD_SIZE-1:0]     t_end;
  logic                     step_init;
  logic                     step_start;
  logic                     step_done;
  logic                     step_proceed;
  logic                     step_error_failure;
  logic [WORD_SIZE-1:0]     step_value;
  logic [ADDRESS_WIDTH-1:0] x0_address;
  logic [ADDRESS_WIDTH-1:0] x1_address;
  logic                     solver_start;
  logic                     solver_done;
  logic [WORD_SIZE-1:0]     solver_step;
  logic                     busy;
  logic                     finished;
  logic                     failed;
  logic [WORD_SIZE-1:0]     time_out;
  logic [WORD_SIZE-1:0]     accepted_count;
  seq_state_t               state_dbg;

  modport master (
    input  go, abort, t_end, step_done, step_proceed, step_error_failure,
           step_value, solver_done,
    output step_init, step_start, x0_address, x1_address, solver_start,
           solver_step, busy, finished, failed, time_out, accepted_count,
           state_dbg
  );

  modport slave (
    output go, abort, t_end, step_done, step_proceed, step_error_failure,
           step_value, solver_done,
    input  step_init, step_start, x0_address, x1_address, solver_start,
           solver_step, busy, finished, failed, time_out, accepted_count,
           state_dbg
  );
endinterface

// File: rtl/ode_step_sequencer_acc.sv
// sat_time_accumulator: simulated-time register with an unsigned
// saturating adder, plus the accepted-step counter.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr_i       : clear time and count (start of a run)
//   acc_en_i    : add step_i to time (saturating) and bump the count
//   step_i      : step to add (expected to be a registered value)
//   sum_o       : saturated time + step_i, for the caller's end-of-run test
//   ovf_o       : the add carried out
//   time_o      : accumulated time
//   count_o     : accepted steps, wraps mod 2^W
module sat_time_accumulator #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         acc_en_i,
  input  logic [W-1:0] step_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o,
  output logic [W-1:0] time_o,
  output logic [W-1:0] count_o
);

  logic [W-1:0] time_q;
  logic [W-1:0] count_q;
  logic [W:0]   raw_sum;

  assign raw_sum = {1'b0, time_q} + {1'b0, step_i};
  assign ovf_o   = raw_sum[W];
  assign sum_o   = raw_sum[W] ? {W{1'b1}} : raw_sum[W-1:0];
  assign time_o  = time_q;
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_q  <= '0;
      count_q <= '0;
    end else if (clr_i) begin
      time_q  <= '0;
      count_q <= '0;
    end else if (acc_en_i) begin
      time_q  <= sum_o;
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/ode_step_sequencer.sv
// ode_step_sequencer: adaptive-step controller for one integration run.
// Initialises the step module, then repeats solve -> check -> accept/retry
// until simulated time reaches t_end (DONE), or the step module reports an
// error / too many consecutive rejections occur (FAIL).
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   bus   : ode_seq_if.master, host/step/solver signals plus state_dbg
module ode_step_sequencer
  import ode_pkg::*;
#(
  parameter int                     WORD_SIZE     = 16,
  parameter int                     ADDRESS_WIDTH = 16,
  parameter int                     MAX_RETRIES   = 8,
  parameter logic [ADDRESS_WIDTH-1:0] BUF_A_BASE  = ADDRESS_WIDTH'(BUF_A_BASE_DEF),
  parameter logic [ADDRESS_WIDTH-1:0] BUF_B_BASE  = ADDRESS_WIDTH'(BUF_B_BASE_DEF)
) (
  input  logic     clk,
  input  logic     rst,
  ode_seq_if.master bus
);

  localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRIES);

  seq_state_t           state_q, state_d;
  logic [RETRY_W-1:0]   retries_q, retries_d;
  logic                 sel_q, sel_d;
  logic [WORD_SIZE-1:0] t_end_q, t_end_d;
  logic [WORD_SIZE-1:0] solver_step_q;
  logic                 step_init_q, step_start_q, solver_start_q;
  logic                 busy_q, finished_q, failed_q;

  logic                 acc_clr, acc_en, acc_ovf;
  logic [WORD_SIZE-1:0] acc_sum;

  sat_time_accumulator #(.W(WORD_SIZE)) u_acc (
    .clk      (clk),
    .rst_n    (rst),
    .clr_i    (acc_clr),
    .acc_en_i (acc_en),
    .step_i   (solver_step_q),
    .sum_o    (acc_sum),
    .ovf_o    (acc_ovf),
    .time_o   (bus.time_out),
    .count_o  (bus.accepted_count)
  );

  // Next-state logic. abort overrides everything, so a done pulse in the
  // same cycle is simply never looked at.
  always_comb begin
    state_d   = state_q;
    retries_d = retries_q;
    sel_d     = sel_q;
    t_end_d   = t_end_q;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (bus.go) begin
            t_end_d   = bus.t_end;
            retries_d = '0;
            sel_d     = 1'b0;
            acc_clr   = 1'b1;
            state_d   = ST_INIT;
          end
        end
        ST_INIT:       state_d = ST_INIT_WAIT;
        ST_INIT_WAIT:  if (bus.step_done) state_d = ST_SOLVE;
        ST_SOLVE:      state_d = ST_SOLVE_WAIT;
        ST_SOLVE_WAIT: if (bus.solver_done) state_d = ST_CHECK;
        ST_CHECK:      state_d = ST_CHECK_WAIT;
        ST_CHECK_WAIT: begin
          if (bus.step_done) begin
            if (bus.step_error_failure) begin
              state_d = ST_FAIL;
            end else if (bus.step_proceed) begin
              state_d = ST_ACCEPT;
            end else begin
              // The step module has already shrunk the step; just retry.
              retries_d = retries_q + 1'b1;
              state_d   = (retries_d == MAX_R) ? ST_FAIL : ST_SOLVE;
            end
          end
        end
        ST_ACCEPT: begin
          acc_en    = 1'b1;
          retries_d = '0;
          sel_d     = ~sel_q;
          // Saturation already yields all ones, but the carry is tested
          // explicitly so the intent stays obvious.
          state_d   = (acc_ovf || (acc_sum >= t_end_q)) ? ST_DONE : ST_SOLVE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // All outputs are registered from the next state, so each strobe is high
  // exactly in the first cycle of its state and solver_step is valid
  // together with solver_start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      retries_q      <= '0;
      sel_q          <= 1'b0;
      t_end_q        <= '0;
      solver_step_q  <= '0;
      step_init_q    <= 1'b0;
      step_start_q   <= 1'b0;
      solver_start_q <= 1'b0;
      busy_q         <= 1'b0;
      finished_q     <= 1'b0;
      failed_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      retries_q      <= retries_d;
      sel_q          <= sel_d;
      t_end_q        <= t_end_d;
      step_init_q    <= (state_d == ST_INIT);
      step_start_q   <= (state_d == ST_CHECK);
      solver_start_q <= (state_d == ST_SOLVE);
      busy_q         <= !((state_d == ST_IDLE) || (state_d == ST_DONE) ||
                          (state_d == ST_FAIL));
      finished_q     <= (state_d == ST_DONE);
      failed_q       <= (state_d == ST_FAIL);
      if (state_d == ST_SOLVE) begin
        solver_step_q <= bus.step_value;
      end
    end
  end

  assign bus.step_init    = step_init_q;
  assign bus.step_start   = step_start_q;
  assign bus.solver_start = solver_start_q;
  assign bus.solver_step  = solver_step_q;
  assign bus.busy         = busy_q;
  assign bus.finished     = finished_q;
  assign bus.failed       = failed_q;
  assign bus.x0_address   = sel_q ? BUF_B_BASE : BUF_A_BASE;
  assign bus.x1_address   = sel_q ? BUF_A_BASE : BUF_B_BASE;
  assign bus.state_dbg    = state_q;

endmodule
